// File: rtl/dmem_responder.sv
// dmem_responder
// Word-addressed data-memory responder for the memory stage. It accepts one
// load/store at a time over a req/ready handshake, waits WAIT_CYCLES cycles,
// performs the access, then presents a single-cycle response (rvalid).
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states before the access (0..15)
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   req          request valid, held stable by the initiator until accepted
//   we           1 = store, 0 = load
//   addr         byte address
//   wd, be       store data and byte-lane enables (be[0] -> wd[7:0])
//   ready        high only in IDLE (decoded from state only)
//   rvalid       high only in RESP, one cycle per transaction
//   rd, err      load data / access error, meaningful while rvalid=1
// Build option:
//   DMEM_BYTEWRITE_EN  when defined, stores write only lanes with be[i]=1;
//                      otherwise be is ignored and stores write all 32 bits.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rd,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [3:0]  be_q;

    // Not reset: contents survive reset, unwritten words read as X.
    logic [31:0] mem [0:DEPTH-1];

    logic [AW-1:0] idx;
    logic          bad;
    logic          access;

    assign idx    = addr_q[AW+1:2];
    // Misaligned, or any address bit above the array span is set.
    assign bad    = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign access = (state == BUSY) && (cnt == 4'd0);

    assign ready  = (state == IDLE);
    assign rvalid = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            we_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            be_q   <= '0;
            rd     <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        addr_q <= addr;
                        wd_q   <= wd;
                        be_q   <= be;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err   <= bad;
                        // Stores and faulting accesses return zero data.
                        rd    <= (bad || we_q) ? '0 : mem[idx];
                        state <= RESP;
                    end
                end
                RESP: begin
                    rd    <= '0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write is qualified by state, so a reset before the access edge
    // (state forced to IDLE) can never commit the store.
    always_ff @(posedge clk) begin
        if (access && we_q && !bad) begin
`ifdef DMEM_BYTEWRITE_EN
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
            end
`else
            mem[idx] <= wd_q;
`endif
        end
    end

`ifndef DMEM_BYTEWRITE_EN
    // Lane enables are captured but have no effect in the full-word build.
    logic unused_be;
    assign unused_be = ^be_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ready;
    logic        rvalid;
    logic [31:0] rd;
    logic        err;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wd(wd), .be(be), .ready(ready), .rvalid(rvalid), .rd(rd), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   rv_cycs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every response is popped against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rvalid === 1'b1) begin
            rv_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got rvalid=1 want none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("rd", rd, e.rd);
                check("err", {31'b0, err}, {31'b0, e.err});
                check("latency", cyc - e.acc, WAIT + 1);
            end
        end
    end

    // Issue one transaction; called and returns at a negedge with ready=1.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        int t;
        int lows;
        exp_t e;
        req = 1'b1; we = w; addr = a; wd = d; be = b;
        t = 0;
        while (ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1");
            req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.rd = exp_rd; e.err = exp_err; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        lows = 0; t = 0;
        while (ready !== 1'b1 && t < 50) begin lows++; @(negedge clk); t++; end
        check("ready_low_cycles", lows, WAIT + 2);
    endtask

    initial begin
        int n0;
        int t;
        exp_t e;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0; be = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Idle: no responses with req low.
        n0 = rv_cycs.size();
        repeat (10) @(negedge clk);
        check("idle_no_rvalid", rv_cycs.size() - n0, 0);
        check("idle_ready", {31'b0, ready}, 32'd1);

        // Basic store/load.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        // Partial-lane store.
        txn(1'b1, 32'h10, 32'h00000055, 4'b0001, 32'h0, 1'b0);
`ifdef DMEM_BYTEWRITE_EN
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBE55, 1'b0);
`else
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'h00000055, 1'b0);
`endif

        // Error handling: faulting stores must not alias onto valid words.
        txn(1'b1, 32'h0FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        txn(1'b1, 32'h000, 32'h01234567, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h012, 32'h0, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h013, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 32'h0FC, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
        txn(1'b0, 32'h000, 32'h0, 4'hF, 32'h01234567, 1'b0);
`ifdef DMEM_BYTEWRITE_EN
        txn(1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADBE55, 1'b0);
`else
        txn(1'b0, 32'h010, 32'h0, 4'hF, 32'h00000055, 1'b0);
`endif

        // req held high across three loads.
        n0 = rv_cycs.size();
        req = 1'b1; we = 1'b0; addr = 32'h0FC; wd = '0; be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            e.rd = 32'hCAFEF00D; e.err = 1'b0; e.acc = cyc;
            sb.push_back(e);
            @(negedge clk);
        end
        req = 1'b0;
        t = 0;
        while (rv_cycs.size() < n0 + 3 && t < 50) begin @(negedge clk); t++; end
        repeat (8) @(negedge clk);
        check("held_req_pulses", rv_cycs.size() - n0, 3);
        if (rv_cycs.size() >= n0 + 3) begin
            check("held_req_gap1", rv_cycs[n0+1] - rv_cycs[n0], WAIT + 3);
            check("held_req_gap2", rv_cycs[n0+2] - rv_cycs[n0+1], WAIT + 3);
        end

        // Reset mid-transaction aborts the store.
        txn(1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0);
        n0 = rv_cycs.size();
        req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h22222222; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_rvalid", {31'b0, rvalid}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_rvalid", rv_cycs.size() - n0, 0);
        check("abort_ready_after", {31'b0, ready}, 32'd1);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 32'h11111111, 1'b0);

        t = 0;
        while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
